// File: rtl/gray_serial_decoder.sv
// gray_serial_decoder
//   Receives a Gray-coded word serially, MSB first, over a valid/ready bit
//   stream. It converts the word to binary on the fly with a running XOR.
//   The finished word, together with the captured Gray word, is presented
//   on a one-deep valid/ready output register.
//
//   Optional feature (macro GRAY_DEC_PARITY_EN): the frame is N+1 bits.
//   The last bit is even parity over the N Gray bits, and out_err flags a
//   parity mismatch. Without the macro the frame is N bits and out_err is 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_bit carries a valid Gray bit
//   in_bit     serial Gray bit, MSB first
//   in_ready   decoder accepts in_bit this cycle
//   out_valid  out_bin/out_gray/out_err hold a complete word
//   out_ready  downstream consumes the word this cycle
//   out_bin    decoded binary word
//   out_gray   Gray word as received
//   out_err    parity error flag (constant 0 without GRAY_DEC_PARITY_EN)
module gray_serial_decoder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_bin,
  output logic [N-1:0] out_gray,
  output logic         out_err
);

`ifdef GRAY_DEC_PARITY_EN
  localparam int FRAME = N + 1;
  // Parity bit completes the frame, so all N data bits live in the shifters.
  localparam int SRW   = N;
`else
  localparam int FRAME = N;
  // g[0] completes the frame straight from in_bit, so N-1 bits suffice.
  localparam int SRW   = N - 1;
`endif
  localparam int            CW   = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FULL = 2'd2} state_e;

  state_e          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  logic            rx_q,       rx_d;       // b[i+1] of the bit in flight
  logic [SRW-1:0]  gray_sr_q,  gray_sr_d;
  logic [SRW-1:0]  bin_sr_q,   bin_sr_d;
  logic [N-1:0]    out_bin_q,  out_bin_d;
  logic [N-1:0]    out_gray_q, out_gray_d;
  logic            out_err_q,  out_err_d;

  logic completing;
  logic accept;
  logic consume;
  logic b_new;
  logic valid_d;

  assign out_valid  = (state_q == FULL);
  assign completing = (cnt_q == LAST);
  // Only a completing bit needs room in the output register.
  assign in_ready   = !(completing && out_valid && !out_ready);
  assign accept     = in_valid && in_ready;
  assign consume    = out_valid && out_ready;

  always_comb begin
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    gray_sr_d  = gray_sr_q;
    bin_sr_d   = bin_sr_q;
    out_bin_d  = out_bin_q;
    out_gray_d = out_gray_q;
    out_err_d  = out_err_q;
    valid_d    = out_valid;
    b_new      = rx_q ^ in_bit;

    if (consume) begin
      valid_d   = 1'b0;
      out_err_d = 1'b0;
    end

    if (accept) begin
      if (completing) begin
        // A new word loading in the consume cycle overrides the drop.
        cnt_d   = '0;
        rx_d    = 1'b0;
        valid_d = 1'b1;
`ifdef GRAY_DEC_PARITY_EN
        out_gray_d = gray_sr_q;
        out_bin_d  = bin_sr_q;
        out_err_d  = in_bit ^ (^gray_sr_q);
`else
        out_gray_d = {gray_sr_q, in_bit};
        out_bin_d  = {bin_sr_q, b_new};
        out_err_d  = 1'b0;
`endif
      end else begin
        cnt_d     = cnt_q + CW'(1);
        rx_d      = b_new;
        gray_sr_d = SRW'({gray_sr_q, in_bit});
        bin_sr_d  = SRW'({bin_sr_q, b_new});
      end
    end

    if (valid_d)
      state_d = FULL;
    else if (cnt_d != '0)
      state_d = SHIFT;
    else
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    gray_sr_q <= gray_sr_d;
    bin_sr_q  <= bin_sr_d;
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= 1'b0;
      out_bin_q  <= '0;
      out_gray_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      out_bin_q  <= out_bin_d;
      out_gray_q <= out_gray_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_bin  = out_bin_q;
  assign out_gray = out_gray_q;
`ifdef GRAY_DEC_PARITY_EN
  assign out_err  = out_err_q;
`else
  assign out_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gray_serial_decoder.sv
module tb_gray_serial_decoder;
  localparam int N = 4;
`ifdef GRAY_DEC_PARITY_EN
  localparam int FRAME = N + 1;
`else
  localparam int FRAME = N;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_bin;
  logic [N-1:0] out_gray;
  logic         out_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic         m_bits[$];
  logic         m_valid;
  logic [N-1:0] m_bin;
  logic [N-1:0] m_gray;
  logic         m_err;
  logic         fb[0:N];

  gray_serial_decoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .out_gray (out_gray),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b = g;
    for (int s = 1; s < N; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cyc(input logic v, input logic b, input logic r);
    logic exp_ready;
    logic [N-1:0] g;
    in_valid  = v;
    in_bit    = b;
    out_ready = r;
    #1;
    exp_ready = !((m_bits.size() == FRAME - 1) && m_valid && !r);
    chk("in_ready", in_ready, exp_ready);
    if (m_valid && r) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    if (v && exp_ready) begin
      m_bits.push_back(b);
      if (m_bits.size() == FRAME) begin
        g = '0;
        for (int i = 0; i < N; i++) g = {g[N-2:0], m_bits[i]};
        m_gray  = g;
        m_bin   = g2b(g);
`ifdef GRAY_DEC_PARITY_EN
        m_err   = m_bits[N] ^ (^g);
`else
        m_err   = 1'b0;
`endif
        m_valid = 1'b1;
        m_bits.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_bin", out_bin, m_bin);
      chk("out_gray", out_gray, m_gray);
      chk("out_err", out_err, m_err);
    end else begin
      chk("out_err_idle", out_err, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_bits.delete();
    m_valid = 1'b0;
    m_bin   = '0;
    m_gray  = '0;
    m_err   = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bin", out_bin, '0);
    chk("rst_out_gray", out_gray, '0);
    chk("rst_out_err", out_err, 1'b0);
  endtask

  task automatic build_frame(input logic [N-1:0] g, input logic flip);
    for (int k = 0; k < N; k++) fb[k] = g[N-1-k];
    fb[N] = (^g) ^ flip;
  endtask

  task automatic send_frame(input logic [N-1:0] g, input int gap, input logic r, input logic flip);
    build_frame(g, flip);
    for (int k = 0; k < FRAME; k++) begin
      cyc(1'b1, fb[k], r);
      if (k < FRAME - 1)
        for (int j = 0; j < gap; j++) cyc(1'b0, 1'b0, r);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_bin = '0; m_gray = '0; m_err = 1'b0;
    do_reset();
    chk("rst_in_ready", in_ready, 1'b1);

    // Single frame 1001, one bit per cycle
    send_frame(4'b1001, 0, 1'b1, 1'b0);
    chk("t1_bin", out_bin, 4'b1110);
    chk("t1_gray", out_gray, 4'b1001);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t1_drop", out_valid, 1'b0);

    // Frame 0111 with 3-cycle gaps
    send_frame(4'b0111, 3, 1'b1, 1'b0);
    chk("t2_bin", out_bin, 4'b0101);
    chk("t2_gray", out_gray, 4'b0111);
    cyc(1'b0, 1'b0, 1'b1);

    // Held word, next frame stalls on its completing bit
    send_frame(4'b1001, 0, 1'b0, 1'b0);
    build_frame(4'b0111, 1'b0);
    for (int k = 0; k < FRAME - 1; k++) cyc(1'b1, fb[k], 1'b0);
    cyc(1'b1, fb[FRAME-1], 1'b0);
    chk("t3_stall", in_ready, 1'b0);
    cyc(1'b1, fb[FRAME-1], 1'b0);
    chk("t3_held_bin", out_bin, 4'b1110);
    cyc(1'b1, fb[FRAME-1], 1'b1);
    chk("t3_swap_valid", out_valid, 1'b1);
    chk("t3_swap_bin", out_bin, 4'b0101);
    cyc(1'b0, 1'b0, 1'b1);

    // Aborted partial frame then reset
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    do_reset();
    send_frame(4'b0010, 0, 1'b1, 1'b0);
    chk("t4_bin", out_bin, 4'b0011);

    // Back-to-back frames
    send_frame(4'b0000, 0, 1'b1, 1'b0);
    chk("t5_bin0", out_bin, 4'b0000);
    send_frame(4'b1000, 0, 1'b1, 1'b0);
    chk("t5_bin1", out_bin, 4'b1111);
    cyc(1'b0, 1'b0, 1'b1);

`ifdef GRAY_DEC_PARITY_EN
    send_frame(4'b1001, 0, 1'b1, 1'b0);
    chk("par_ok_err", out_err, 1'b0);
    chk("par_ok_bin", out_bin, 4'b1110);
    send_frame(4'b1001, 0, 1'b1, 1'b1);
    chk("par_bad_err", out_err, 1'b1);
    chk("par_bad_bin", out_bin, 4'b1110);
    cyc(1'b0, 1'b0, 1'b1);
    chk("par_err_clear", out_err, 1'b0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
